player_ctrl: RTL and testbench

Parametrised player controller for the fighting-game core. It turns the left/right/attack inputs into a movement and attack state machine. It steps and clamps the player's x position once per game frame and sequences a three-phase timed attack that cannot be interrupted. Each player instance sits between the input debouncer and the renderer/hit-detection logic and drives the sprite coordinates plus a hitbox-active flag.

---
 rtl/demoman_pkg.sv | 20 ++
 rtl/player_ctrl_if.sv | 27 ++
 rtl/phase_counter.sv | 26 ++
 rtl/player_ctrl.sv | 150 +++++++++++++++
 tb/tb_player_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demoman_pkg.sv
// rtl/demoman_pkg.sv - shared state encodings and side constants for the player controller
package demoman_pkg;

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_MOVE_FWD     = 3'd1,
      S_MOVE_BWD     = 3'd2,
      S_ATK_STARTUP  = 3'd3,
      S_ATK_ACTIVE   = 3'd4,
      S_ATK_RECOVERY = 3'd5
   } state_t;

   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;

   function automatic logic is_attack(input state_t s);
      return (s == S_ATK_STARTUP) || (s == S_ATK_ACTIVE) || (s == S_ATK_RECOVERY);
   endfunction

endpackage

// File: rtl/player_ctrl_if.sv
// rtl/player_ctrl_if.sv - frame/input and sprite/hitbox signal bundle between debouncer, controller and renderer
interface player_ctrl_if import demoman_pkg::*; #(
   parameter int POS_W = 17
) ();

   logic             tick;
   logic             side;
   logic             left;
   logic             right;
   logic             attack;
   logic [POS_W-1:0] posx;
   logic [POS_W-1:0] posy;
   state_t           state;
   logic             hitbox_active;
   logic             busy;

   modport master (
      output tick, side, left, right, attack,
      input  posx, posy, state, hitbox_active, busy
   );

   modport slave (
      input  tick, side, left, right, attack,
      output posx, posy, state, hitbox_active, busy
   );

endinterface

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - attack phase frame counter, clear wins over enable
module phase_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - per-player movement/attack FSM with frame-stepped, wall-clamped x position
module player_ctrl import demoman_pkg::*; #(
   parameter int POS_W        = 17,
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 600,
   parameter int START_X      = 100,
   parameter int START_Y      = 300,
   parameter int SPEED_FWD    = 3,
   parameter int SPEED_BWD    = 2,
   parameter int ATK_STARTUP  = 5,
   parameter int ATK_ACTIVE   = 3,
   parameter int ATK_RECOVERY = 8,
   parameter int CNT_W        = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   player_ctrl_if.slave io
);

   localparam logic [CNT_W-1:0] LP_END_S = CNT_W'(ATK_STARTUP - 1);
   localparam logic [CNT_W-1:0] LP_END_A = CNT_W'(ATK_ACTIVE - 1);
   localparam logic [CNT_W-1:0] LP_END_R = CNT_W'(ATK_RECOVERY - 1);

   localparam logic signed [POS_W+1:0] LP_XMIN  = (POS_W+2)'(X_MIN);
   localparam logic signed [POS_W+1:0] LP_XMAX  = (POS_W+2)'(X_MAX);
   localparam logic signed [POS_W+1:0] LP_SPD_F = (POS_W+2)'(SPEED_FWD);
   localparam logic signed [POS_W+1:0] LP_SPD_B = (POS_W+2)'(SPEED_BWD);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [POS_W-1:0]         r_posx;
   logic [POS_W-1:0]         w_posx_nxt;
   logic [CNT_W-1:0]         w_count;
   logic [CNT_W-1:0]         w_len_end;
   logic                     w_phase_end;
   logic                     w_clr;
   logic                     w_busy;
   logic                     w_dir_pos;
   logic                     w_dir_neg;
   logic                     w_fwd_req;
   logic                     w_bwd_req;
   logic                     w_moving;
   logic                     w_step_up;
   logic signed [POS_W+1:0]  w_step;
   logic signed [POS_W+1:0]  w_cand;

   assign w_busy    = is_attack(r_state);
   assign w_dir_pos = io.right & ~io.left;
   assign w_dir_neg = io.left & ~io.right;
   assign w_fwd_req = (io.side == LEFT)  ? w_dir_pos : w_dir_neg;
   assign w_bwd_req = (io.side == RIGHT) ? w_dir_pos : w_dir_neg;

   phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (io.tick & w_busy),
      .clr   (w_clr),
      .count (w_count)
   );

   always_comb begin
      w_len_end = '0;
      case (r_state)
         S_ATK_STARTUP:  w_len_end = LP_END_S;
         S_ATK_ACTIVE:   w_len_end = LP_END_A;
         S_ATK_RECOVERY: w_len_end = LP_END_R;
         default:        w_len_end = '0;
      endcase
   end

   assign w_phase_end = (w_count == w_len_end);

   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      if (io.tick) begin
         case (r_state)
            S_IDLE, S_MOVE_FWD, S_MOVE_BWD: begin
               if (io.attack) begin
                  w_state_nxt = S_ATK_STARTUP;
                  w_clr       = 1'b1;
               end else if (w_fwd_req) begin
                  w_state_nxt = S_MOVE_FWD;
               end else if (w_bwd_req) begin
                  w_state_nxt = S_MOVE_BWD;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_ATK_STARTUP: begin
               if (w_phase_end) begin
                  w_state_nxt = S_ATK_ACTIVE;
                  w_clr       = 1'b1;
               end
            end
            S_ATK_ACTIVE: begin
               if (w_phase_end) begin
                  w_state_nxt = S_ATK_RECOVERY;
                  w_clr       = 1'b1;
               end
            end
            S_ATK_RECOVERY: begin
               if (w_phase_end) begin
                  w_state_nxt = S_IDLE;
                  w_clr       = 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Step sign comes from the live side input; signed arithmetic with two spare bits so clamping never wraps.
   assign w_moving  = (r_state == S_MOVE_FWD) || (r_state == S_MOVE_BWD);
   assign w_step_up = (r_state == S_MOVE_FWD) == (io.side == LEFT);

   always_comb begin
      w_step = (r_state == S_MOVE_FWD) ? LP_SPD_F : LP_SPD_B;
      if (!w_step_up) begin
         w_step = -w_step;
      end
      w_cand = $signed({2'b00, r_posx}) + w_step;
      if (w_cand < LP_XMIN) begin
         w_posx_nxt = LP_XMIN[POS_W-1:0];
      end else if (w_cand > LP_XMAX) begin
         w_posx_nxt = LP_XMAX[POS_W-1:0];
      end else begin
         w_posx_nxt = w_cand[POS_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_posx  <= POS_W'(START_X);
      end else if (io.tick) begin
         r_state <= w_state_nxt;
         if (w_moving) begin
            r_posx <= w_posx_nxt;
         end
      end
   end

   assign io.state         = r_state;
   assign io.posx          = r_posx;
   assign io.posy          = POS_W'(START_Y);
   assign io.hitbox_active = (r_state == S_ATK_ACTIVE);
   assign io.busy          = w_busy;

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - directed self-checking bench for player_ctrl
module tb_player_ctrl;
   import demoman_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   player_ctrl_if #(.POS_W(17)) io ();

   player_ctrl #(
      .POS_W(17), .X_MIN(0), .X_MAX(600), .START_X(100), .START_Y(300),
      .SPEED_FWD(3), .SPEED_BWD(2), .ATK_STARTUP(5), .ATK_ACTIVE(3),
      .ATK_RECOVERY(8), .CNT_W(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      io.tick   = 1'b0;
      io.side   = 1'b0;
      io.left   = 1'b0;
      io.right  = 1'b0;
      io.attack = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         io.tick = 1'b1;
         @(negedge clk);
         io.tick = 1'b0;
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (io.state !== S_IDLE) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", io.state); end
      n_checks++;
      if (io.posx !== 17'd100) begin n_errors++; $display("FAIL reset_posx got=%0d exp=100", io.posx); end
      n_checks++;
      if (io.posy !== 17'd300) begin n_errors++; $display("FAIL reset_posy got=%0d exp=300", io.posy); end
      n_checks++;
      if (io.hitbox_active !== 1'b0 || io.busy !== 1'b0) begin
         n_errors++; $display("FAIL reset_flags got hit=%b busy=%b exp 0 0", io.hitbox_active, io.busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_move_fwd();
      apply_reset();
      io.side = 1'b0; io.right = 1'b1;
      do_ticks(1);
      n_checks++;
      if (io.state !== S_MOVE_FWD || io.posx !== 17'd100) begin
         n_errors++; $display("FAIL fwd_tick1 got st=%0d x=%0d exp st=1 x=100", io.state, io.posx);
      end
      do_ticks(1);
      n_checks++;
      if (io.posx !== 17'd103) begin n_errors++; $display("FAIL fwd_tick2 got x=%0d exp 103", io.posx); end
      do_ticks(8);
      n_checks++;
      if (io.posx !== 17'd127) begin n_errors++; $display("FAIL fwd_tick10 got x=%0d exp 127", io.posx); end
      io.right = 1'b0;
      do_ticks(1);
      n_checks++;
      if (io.state !== S_IDLE || io.posx !== 17'd130) begin
         n_errors++; $display("FAIL fwd_release got st=%0d x=%0d exp st=0 x=130", io.state, io.posx);
      end
      do_ticks(2);
      n_checks++;
      if (io.posx !== 17'd130) begin n_errors++; $display("FAIL fwd_hold got x=%0d exp 130", io.posx); end
   endtask

   task automatic test_walls();
      apply_reset();
      io.side = 1'b1; io.right = 1'b1;
      do_ticks(1);
      n_checks++;
      if (io.state !== S_MOVE_BWD) begin n_errors++; $display("FAIL bwd_state got=%0d exp 2", io.state); end
      do_ticks(2);
      n_checks++;
      if (io.posx !== 17'd104) begin n_errors++; $display("FAIL bwd_step got x=%0d exp 104", io.posx); end
      do_ticks(248);
      n_checks++;
      if (io.posx !== 17'd600) begin n_errors++; $display("FAIL right_wall got x=%0d exp 600", io.posx); end
      do_ticks(5);
      n_checks++;
      if (io.posx !== 17'd600) begin n_errors++; $display("FAIL right_wall_hold got x=%0d exp 600", io.posx); end
      // forward toward the left wall; 100 is not a multiple of 3 so the last step clamps
      apply_reset();
      io.side = 1'b1; io.left = 1'b1;
      do_ticks(34);
      n_checks++;
      if (io.posx !== 17'd1) begin n_errors++; $display("FAIL left_near got x=%0d exp 1", io.posx); end
      do_ticks(1);
      n_checks++;
      if (io.posx !== 17'd0) begin n_errors++; $display("FAIL left_wall got x=%0d exp 0", io.posx); end
      do_ticks(3);
      n_checks++;
      if (io.posx !== 17'd0 || io.state !== S_MOVE_FWD) begin
         n_errors++; $display("FAIL left_wall_hold got x=%0d st=%0d exp x=0 st=1", io.posx, io.state);
      end
   endtask

   task automatic test_attack();
      logic [2:0] exp_st;
      apply_reset();
      io.attack = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         do_ticks(1);
         if (k == 1) begin io.attack = 1'b0; io.left = 1'b1; end
         exp_st = (k <= 5)  ? 3'd3 :
                  (k <= 8)  ? 3'd4 :
                  (k <= 16) ? 3'd5 :
                  (k == 17) ? 3'd0 : 3'd2;
         n_checks++;
         if (io.state !== exp_st) begin
            n_errors++; $display("FAIL atk_state tick=%0d got=%0d exp=%0d", k, io.state, exp_st);
         end
         n_checks++;
         if (io.busy !== (k <= 16) || io.hitbox_active !== (k >= 6 && k <= 8)) begin
            n_errors++; $display("FAIL atk_flags tick=%0d got busy=%b hit=%b", k, io.busy, io.hitbox_active);
         end
      end
      n_checks++;
      if (io.posx !== 17'd98) begin n_errors++; $display("FAIL atk_then_bwd got x=%0d exp 98", io.posx); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      io.attack = 1'b1; io.left = 1'b1;
      do_ticks(3);
      io.side = 1'b1;
      do_ticks(13);
      n_checks++;
      if (io.state !== S_ATK_RECOVERY) begin n_errors++; $display("FAIL b2b_t16 got=%0d exp 5", io.state); end
      do_ticks(1);
      n_checks++;
      if (io.state !== S_IDLE) begin n_errors++; $display("FAIL b2b_t17 got=%0d exp 0", io.state); end
      do_ticks(1);
      n_checks++;
      if (io.state !== S_ATK_STARTUP || io.posx !== 17'd100) begin
         n_errors++; $display("FAIL b2b_t18 got st=%0d x=%0d exp st=3 x=100", io.state, io.posx);
      end
   endtask

   task automatic test_both_dirs();
      apply_reset();
      io.right = 1'b1;
      do_ticks(2);
      io.left = 1'b1;
      do_ticks(1);
      n_checks++;
      if (io.state !== S_IDLE || io.posx !== 17'd106) begin
         n_errors++; $display("FAIL both_dirs got st=%0d x=%0d exp st=0 x=106", io.state, io.posx);
      end
      do_ticks(2);
      n_checks++;
      if (io.posx !== 17'd106) begin n_errors++; $display("FAIL both_hold got x=%0d exp 106", io.posx); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      io.right = 1'b1;
      do_ticks(3);
      io.right = 1'b0; io.attack = 1'b1;
      do_ticks(1);
      io.attack = 1'b0;
      do_ticks(5);
      n_checks++;
      if (io.hitbox_active !== 1'b1 || io.posx !== 17'd109) begin
         n_errors++; $display("FAIL pre_rst got hit=%b x=%0d exp hit=1 x=109", io.hitbox_active, io.posx);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (io.state !== S_IDLE || io.hitbox_active !== 1'b0 || io.busy !== 1'b0 || io.posx !== 17'd100) begin
         n_errors++;
         $display("FAIL async_rst got st=%0d hit=%b busy=%b x=%0d exp 0 0 0 100",
                  io.state, io.hitbox_active, io.busy, io.posx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_ticks(3);
      n_checks++;
      if (io.state !== S_IDLE || io.posx !== 17'd100) begin
         n_errors++; $display("FAIL post_rst got st=%0d x=%0d exp 0 100", io.state, io.posx);
      end
   endtask

   task automatic test_tick_hold();
      apply_reset();
      io.right = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (io.state !== S_IDLE || io.posx !== 17'd100) begin
         n_errors++; $display("FAIL hold_idle got st=%0d x=%0d exp 0 100", io.state, io.posx);
      end
      do_ticks(1);
      repeat (20) @(negedge clk);
      n_checks++;
      if (io.state !== S_MOVE_FWD || io.posx !== 17'd100) begin
         n_errors++; $display("FAIL hold_move got st=%0d x=%0d exp 1 100", io.state, io.posx);
      end
      do_ticks(1);
      n_checks++;
      if (io.posx !== 17'd103) begin n_errors++; $display("FAIL hold_resume got x=%0d exp 103", io.posx); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_move_fwd();
      test_walls();
      test_attack();
      test_back_to_back();
      test_both_dirs();
      test_async_reset();
      test_tick_hold();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
